pipelined_addsub: RTL

- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 32-bit combinational ripple adder.
- The WIDTH-bit carry chain is cut into STAGES ripple segments, one segment per clock.
- Operands and results are skewed and de-skewed so one operation per cycle is accepted.
- Valid/ready handshakes on both sides; carry, overflow and zero flags returned; feeds the ALU result mux.

---
 rtl/alu_pkg.sv | 18 +
 rtl/adder_segment.sv | 29 ++
 rtl/full_adder.sv | 13 +
 rtl/pipelined_addsub.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, default datapath width and the
// flag bundle returned by the arithmetic units.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG_W-bit ripple adder made of full_adder cells; one segment
// of the pipelined carry chain.
module adder_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             c_in,
    output logic [SEG_W-1:0] sum,
    output logic             c_out
);

    logic [SEG_W:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .sum   (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out = carry[SEG_W];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of every ripple segment.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one SEG_W carry segment per stage, skewed operands,
// de-skewed result. Define PIPELINED_ADDSUB_SAT_EN to saturate on overflow.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG_W = WIDTH / STAGES;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    alu_flags_t       flags_q;

    // Subtraction is a + ~b + ~c_in, so the borrow-in folds into the carry-in.
    assign b_eff    = (op_sub == OP_SUB) ? ~b : b;
    assign carry0   = (op_sub == OP_SUB) ? ~c_in : c_in;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG_W;     // result bits already resolved
        localparam int REM = WIDTH - LO;    // operand bits still to be added

        logic [REM-1:0]      src_a;
        logic [REM-1:0]      src_b;
        logic                src_c;
        logic                src_v;
        logic [LO+SEG_W-1:0] res;
        logic [SEG_W-1:0]    seg_s;
        logic                seg_c;

        if (k == 0) begin : g_src
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = carry0;
            assign src_v = in_valid;
            assign res   = seg_s;
        end else begin : g_src
            assign src_a = g_stage[k-1].g_reg.a_q;
            assign src_b = g_stage[k-1].g_reg.b_q;
            assign src_c = g_stage[k-1].g_reg.c_q;
            assign src_v = g_stage[k-1].g_reg.v_q;
            assign res   = {seg_s, g_stage[k-1].g_reg.s_q};
        end

        adder_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a     (src_a[SEG_W-1:0]),
            .b     (src_b[SEG_W-1:0]),
            .c_in  (src_c),
            .sum   (seg_s),
            .c_out (seg_c)
        );

        if (k < STAGES - 1) begin : g_reg
            logic                 v_q;
            logic                 c_q;
            logic [REM-SEG_W-1:0] a_q;
            logic [REM-SEG_W-1:0] b_q;
            logic [LO+SEG_W-1:0]  s_q;

            // NOTE: sequential state is written with non-blocking assignments only.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= src_v;
                end
            end

            // NOTE: the datapath has no reset; the valid bit alone says whether it holds a beat.
            always_ff @(posedge clk) begin
                if (advance) begin
                    c_q <= seg_c;
                    a_q <= src_a[REM-1:SEG_W];
                    b_q <= src_b[REM-1:SEG_W];
                    s_q <= res;
                end
            end
        end else begin : g_fin
            logic [WIDTH-1:0] sum_fin;
            alu_flags_t       flags_fin;

            // NOTE: defaults come first so no path through always_comb leaves a latch.
            always_comb begin
                sum_fin         = res;
                flags_fin.c_out = seg_c;
                flags_fin.ovf   = (src_a[SEG_W-1] == src_b[SEG_W-1]) &&
                                  (seg_s[SEG_W-1] != src_a[SEG_W-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
                if (flags_fin.ovf) begin
                    sum_fin = src_a[SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
                flags_fin.zero  = ~|sum_fin;
            end

            // Result registers only load real beats, so they hold the last result over bubbles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    flags_q     <= '0;
                end else if (advance) begin
                    out_valid_q <= src_v;
                    if (src_v) begin
                        sum_q   <= sum_fin;
                        flags_q <= flags_fin;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = flags_q.c_out;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

endmodule
